// File: rtl/target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : target_pkg
// Description : Shared constants, state encoding and window helpers for the
//               target lock controller and the pixel mixer.
// Revision    : 1.0 - initial release
// ============================================================================
package target_pkg;

    localparam int NUM_TARGETS = 16;
    localparam int IDX_W       = $clog2(NUM_TARGETS);

    localparam logic [9:0] CX_MIN_DEF = 10'd288;
    localparam logic [9:0] CX_MAX_DEF = 10'd351;
    localparam logic [9:0] CY_MIN_DEF = 10'd208;
    localparam logic [9:0] CY_MAX_DEF = 10'd271;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_LOCKED = 2'd2,
        S_COAST  = 2'd3
    } lock_state_t;

    // Inclusive rectangle test on 10-bit screen coordinates.
    function automatic logic in_window(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] x_lo,
        input logic [9:0] x_hi,
        input logic [9:0] y_lo,
        input logic [9:0] y_hi
    );
        return (x >= x_lo) && (x <= x_hi) && (y >= y_lo) && (y <= y_hi);
    endfunction

    // Cursor-in-box test; cursor is zero-extended to the 12-bit box space.
    function automatic logic in_box(
        input logic [9:0]  mx,
        input logic [9:0]  my,
        input logic [11:0] bx_lo,
        input logic [11:0] bx_hi,
        input logic [11:0] by_lo,
        input logic [11:0] by_hi
    );
        logic [11:0] ex;
        logic [11:0] ey;
        ex = {2'b00, mx};
        ey = {2'b00, my};
        return (ex >= bx_lo) && (ex <= bx_hi) && (ey >= by_lo) && (ey <= by_hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/click_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : click_edge_det
// Description : Registers both mouse buttons and flags their rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module click_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic click_l,
    input  logic click_r,
    output logic edge_l,
    output logic edge_r
);

    logic r_cur_l;
    logic r_prev_l;
    logic r_cur_r;
    logic r_prev_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_l  <= 1'b0;
            r_prev_l <= 1'b0;
            r_cur_r  <= 1'b0;
            r_prev_r <= 1'b0;
        end else begin
            r_cur_l  <= click_l;
            r_prev_l <= r_cur_l;
            r_cur_r  <= click_r;
            r_prev_r <= r_cur_r;
        end
    end

    // Both terms are flops, so the edge flags are glitch-free.
    assign edge_l = r_cur_l & ~r_prev_l;
    assign edge_r = r_cur_r & ~r_prev_r;

endmodule
`default_nettype wire

// File: rtl/target_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : target_lock_ctrl
// Description : Click-to-lock target tracker: serial box search, frame-based
//               lock maintenance with coast-through of missed detections.
// Revision    : 1.0 - initial release
// ============================================================================
module target_lock_ctrl
    import target_pkg::*;
#(
    parameter int         LOST_FRAMES = 8,
    parameter logic [9:0] CX_MIN      = CX_MIN_DEF,
    parameter logic [9:0] CX_MAX      = CX_MAX_DEF,
    parameter logic [9:0] CY_MIN      = CY_MIN_DEF,
    parameter logic [9:0] CY_MAX      = CY_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [15:0]      aim_detected_all,
    input  logic [15:0][9:0] aim_x_all,
    input  logic [15:0][9:0] aim_y_all,
    input  logic [15:0][11:0] box_x_min_all,
    input  logic [15:0][11:0] box_x_max_all,
    input  logic [15:0][11:0] box_y_min_all,
    input  logic [15:0][11:0] box_y_max_all,
    input  logic [9:0]       mouse_x_pixel,
    input  logic [9:0]       mouse_y_pixel,
    input  logic             click_l,
    input  logic             click_r,
    input  logic             target_off,
    output logic             is_locked,
    output logic [3:0]       locked_idx,
    output logic             center_hit,
    output logic [1:0]       lock_state
);

    localparam int c_MISS_W = $clog2(LOST_FRAMES + 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_TARGETS - 1);

    lock_state_t         r_state;
    logic                r_is_locked;
    logic [IDX_W-1:0]    r_locked_idx;
    logic                r_center_hit;
    logic [c_MISS_W-1:0] r_miss_cnt;
    logic [IDX_W-1:0]    r_scan_idx;
    logic [9:0]          r_mouse_x;
    logic [9:0]          r_mouse_y;

    logic w_edge_l;
    logic w_edge_r;
    logic w_hit;
    logic w_lock_det;
    logic w_lock_centered;
    logic w_miss_last;

    click_edge_det u_click_edge_det (
        .clk     (clk),
        .reset   (reset),
        .click_l (click_l),
        .click_r (click_r),
        .edge_l  (w_edge_l),
        .edge_r  (w_edge_r)
    );

    // Only the entry selected by scan_idx is compared each cycle.
    always_comb begin
        w_hit = aim_detected_all[r_scan_idx] &&
                in_box(r_mouse_x, r_mouse_y,
                       box_x_min_all[r_scan_idx], box_x_max_all[r_scan_idx],
                       box_y_min_all[r_scan_idx], box_y_max_all[r_scan_idx]);
    end

    always_comb begin
        w_lock_det      = aim_detected_all[r_locked_idx];
        w_lock_centered = in_window(aim_x_all[r_locked_idx], aim_y_all[r_locked_idx],
                                    CX_MIN, CX_MAX, CY_MIN, CY_MAX);
        w_miss_last     = (int'(r_miss_cnt) + 1) >= LOST_FRAMES;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_is_locked  <= 1'b0;
            r_locked_idx <= '0;
            r_center_hit <= 1'b0;
            r_miss_cnt   <= '0;
            r_scan_idx   <= '0;
            r_mouse_x    <= '0;
            r_mouse_y    <= '0;
        end else if (target_off || w_edge_r) begin
            // Forced unlock; locked_idx deliberately keeps its last value.
            r_state      <= S_IDLE;
            r_is_locked  <= 1'b0;
            r_center_hit <= 1'b0;
            r_miss_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_edge_l) begin
                        r_mouse_x  <= mouse_x_pixel;
                        r_mouse_y  <= mouse_y_pixel;
                        r_scan_idx <= '0;
                        r_state    <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_hit) begin
                        r_state      <= S_LOCKED;
                        r_is_locked  <= 1'b1;
                        r_locked_idx <= r_scan_idx;
                    end else if (r_scan_idx == c_LAST_IDX) begin
                        r_state      <= S_IDLE;
                        r_center_hit <= 1'b0;
                        r_miss_cnt   <= '0;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (frame_tick) begin
                        if (w_lock_det) begin
                            r_center_hit <= w_lock_centered;
                        end else begin
                            r_miss_cnt   <= c_MISS_W'(1);
                            r_center_hit <= 1'b0;
                            r_state      <= S_COAST;
                        end
                    end
                end
                S_COAST: begin
                    if (frame_tick) begin
                        if (w_lock_det) begin
                            r_miss_cnt <= '0;
                            r_state    <= S_LOCKED;
                        end else if (w_miss_last) begin
                            r_miss_cnt   <= '0;
                            r_center_hit <= 1'b0;
                            r_is_locked  <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_is_locked <= 1'b0;
                end
            endcase
        end
    end

    assign is_locked  = r_is_locked;
    assign locked_idx = r_locked_idx;
    assign center_hit = r_center_hit;
    assign lock_state = r_state;

endmodule
`default_nettype wire

// File: doc/target_lock_ctrl.md
TARGET_LOCK_CTRL -- requirements
Module: target_lock_ctrl

Interface
REQ-001 SHALL have parameter LOST_FRAMES, default 8: consecutive missed frames before a lock drops.
REQ-002 SHALL have parameters CX_MIN/CX_MAX/CY_MIN/CY_MAX, defaults 288/351/208/271: inclusive centre window.
REQ-003 SHALL have port clk, input, 1: single clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port frame_tick, input, 1: one-cycle pulse once per frame, at vblank start.
REQ-006 SHALL have port aim_detected_all, input, [15:0]: per-target detect flags.
REQ-007 SHALL have ports aim_x_all and aim_y_all, input, [15:0][9:0]: target centres.
REQ-008 SHALL have ports box_x_min_all, box_x_max_all, box_y_min_all and box_y_max_all, input, [15:0][11:0]: target boxes.
REQ-009 SHALL have ports mouse_x_pixel and mouse_y_pixel, input, [9:0]: cursor position.
REQ-010 SHALL have ports click_l and click_r, input, 1: level mouse buttons.
REQ-011 SHALL have port target_off, input, 1: level; forces unlock.
REQ-012 SHALL have port is_locked, output, 1: high in LOCKED or COAST.
REQ-013 SHALL have port locked_idx, output, [3:0]: index of the locked target.
REQ-014 SHALL have port center_hit, output, 1: locked aim is inside the centre window.
REQ-015 SHALL have port lock_state, output, [1:0]: current FSM state.

Function
REQ-016 SHALL register click_l and click_r; a rising edge is current=1 with previous=0.
REQ-017 SHALL implement FSM states IDLE=0, SEARCH=1, LOCKED=2, COAST=3.
REQ-018 SHALL, on a click_l edge in IDLE at cycle n, latch the mouse coordinates, clear scan_idx, and enter SEARCH at n+1.
REQ-019 SHALL, in SEARCH, test one index per cycle in order 0..15: hit = detected[k] and box_x_min<=mx<=box_x_max and box_y_min<=my<=box_y_max, with mouse values zero-extended to 12 bits.
REQ-020 SHALL, on the first hit at index k, enter LOCKED with locked_idx=k on the next cycle; worst-case lock latency is 17 cycles after the edge.
REQ-021 SHALL return to IDLE when index 15 is tested without a hit; scan_idx SHALL NOT wrap.
REQ-022 SHALL, in LOCKED on frame_tick: if detected[locked_idx], update center_hit from the aim position against the inclusive window; otherwise set miss_cnt=1, center_hit=0, and enter COAST.
REQ-023 SHALL, in COAST on frame_tick: if detected, clear miss_cnt and enter LOCKED; otherwise increment miss_cnt and enter IDLE when miss_cnt reaches LOST_FRAMES.
REQ-024 SHALL update center_hit only on frame_tick and hold it between ticks.
REQ-025 SHALL ignore click_l edges in SEARCH, LOCKED and COAST.
REQ-026 SHALL, on a click_r edge in any state, enter IDLE on the next cycle.
REQ-027 SHALL give click_r priority when click_l and click_r edges coincide.
REQ-028 SHALL force IDLE while target_off=1 and ignore click edges; it SHALL outrank all other events except reset.
REQ-029 SHALL, on entering IDLE, clear center_hit and miss_cnt; locked_idx SHALL hold its last value.
REQ-030 SHALL, when frame_tick coincides with a click_r edge, give click_r priority.
REQ-031 SHALL size miss_cnt to $clog2(LOST_FRAMES+1) bits, non-saturating; it can never exceed LOST_FRAMES.

Reset
REQ-032 SHALL, on synchronous reset, set state=IDLE, is_locked=0, locked_idx=0, center_hit=0, lock_state=0, miss_cnt=0, scan_idx=0, click history=0.
REQ-033 SHALL abandon an in-progress SEARCH or COAST on reset; the first cycle after reset release is IDLE.

Structure
REQ-034 SHALL place NUM_TARGETS=16, the lock_state_t enum and the centre-window defaults in shared package target_pkg; the pixel mixer SHALL use the same package.
REQ-035 SHALL instantiate one sub-module, click_edge_det, covering both buttons; all other logic is inline.
REQ-036 SHALL keep every output registered; the per-cycle search comparators act on one index only, with no 16-way parallel compare.

Verification
REQ-037 SHALL verify: targets 3 and 7 detected, mouse (100,100) inside box 7 only, click_l -> LOCKED with locked_idx=7 at edge+9.
REQ-038 SHALL verify: no box contains the mouse, click_l -> SEARCH for 16 cycles, then IDLE, is_locked=0.
REQ-039 SHALL verify: locked target aim at (320,240) -> center_hit=1 after frame_tick; aim at (287,240) -> center_hit=0.
REQ-040 SHALL verify: locked target undetected for 7 ticks, then detected -> back to LOCKED; undetected for 8 ticks -> IDLE on the 8th tick.
REQ-041 SHALL verify: simultaneous click_l and click_r edges while LOCKED -> IDLE next cycle; target_off=1 held -> click_l ignored.
REQ-042 SHALL verify: reset asserted mid-SEARCH at index 5 -> all outputs 0 the next cycle, state IDLE.
